// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: same-cycle hit path, and a full-line refill
// over a req/ack memory bus on a miss.
module inst_cache #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce,
    input  logic [31:0] rom_addr,
    output logic [31:0] rom_inst,
    output logic        stallreq_if,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << (INDEX_BITS + OFFSET_BITS);
    localparam int TAG_BITS = 32 - 2 - OFFSET_BITS - INDEX_BITS;
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

    typedef enum logic {IDLE, REFILL} state_e;

    state_e                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic                   mem_req_q, mem_req_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [INDEX_BITS-1:0]  line_idx_q, line_idx_d;
    logic [TAG_BITS-1:0]    line_tag_q, line_tag_d;

    logic [TAG_BITS-1:0]    tag_mem  [LINES];
    logic [31:0]            data_mem [WORDS];
    logic                   data_we, tag_we;

    logic [OFFSET_BITS-1:0] off;
    logic [INDEX_BITS-1:0]  idx;
    logic [TAG_BITS-1:0]    tag;
    logic                   hit;
    logic                   unused_addr_bits;

    assign off = rom_addr[2 +: OFFSET_BITS];
    assign idx = rom_addr[2 + OFFSET_BITS +: INDEX_BITS];
    assign tag = rom_addr[31 -: TAG_BITS];
    assign unused_addr_bits = ^rom_addr[1:0];

    assign hit         = rom_ce && valid_q[idx] && (tag_mem[idx] == tag);
    assign rom_inst    = hit ? data_mem[{idx, off}] : 32'h0;
    assign stallreq_if = rom_ce && !hit;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d      = state_q;
        valid_d      = valid_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        line_idx_d   = line_idx_q;
        line_tag_d   = line_tag_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        case (state_q)
            IDLE: begin
                // A flush wins over a simultaneous miss; the miss retries next cycle.
                if (flush) begin
                    valid_d = '0;
                end else if (rom_ce && !hit) begin
                    line_idx_d = idx;
                    line_tag_d = tag;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {tag, idx, {(OFFSET_BITS + 2){1'b0}}};
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (flush) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    data_we    = 1'b1;
                    cnt_d      = cnt_q + OFFSET_BITS'(1);
                    mem_addr_d = mem_addr_q + 32'd4;
                    if (cnt_q == LAST_WORD) begin
                        tag_we = 1'b1;
                        // A flush seen at any point of this refill leaves the line invalid.
                        if (!flush && !flush_pend_q)
                            valid_d[line_idx_q] = 1'b1;
                        mem_req_d    = 1'b0;
                        flush_pend_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            line_idx_q   <= '0;
            line_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            line_idx_q   <= line_idx_d;
            line_tag_q   <= line_tag_d;
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone gate every hit.
    always_ff @(posedge clk) begin
        if (!rst && data_we)
            data_mem[{line_idx_q, cnt_q}] <= mem_rdata;
        if (!rst && tag_we)
            tag_mem[line_idx_q] <= line_tag_q;
    end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a cycle-by-cycle vector table plus hand-written
// sequences for wait states, flushes and reset during a refill.
module tb_inst_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        stallreq_if;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    inst_cache dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst),
        .stallreq_if(stallreq_if),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic        ack;
        logic [31:0] rdata;
        logic [31:0] e_inst;
        logic        e_stall;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply inputs just after a rising edge, then wait to the falling edge to sample.
    task automatic set_in(input logic ce, input logic [31:0] a, input logic fl,
                          input logic ack, input logic [31:0] rd);
        rom_ce    = ce;
        rom_addr  = a;
        flush     = fl;
        mem_ack   = ack;
        mem_rdata = rd;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // mem_addr is only defined while a request is outstanding.
    task automatic expect_out(input string nm, input logic [31:0] e_inst, input logic e_stall,
                              input logic e_req, input logic [31:0] e_addr);
        check({nm, " inst"},  rom_inst,          e_inst);
        check({nm, " stall"}, 32'(stallreq_if),  32'(e_stall));
        check({nm, " req"},   32'(mem_req),      32'(e_req));
        if (e_req)
            check({nm, " addr"}, mem_addr, e_addr);
    endtask

    initial begin
        // ce, addr, ack, rdata | inst, stall, req, mem_addr
        // Cold miss with zero-wait memory
        vq.push_back('{1'b1, 32'h100, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h0});
        vq.push_back('{1'b1, 32'h100, 1'b1, 32'h11, 32'h0,  1'b1, 1'b1, 32'h100});
        vq.push_back('{1'b1, 32'h100, 1'b1, 32'h22, 32'h0,  1'b1, 1'b1, 32'h104});
        vq.push_back('{1'b1, 32'h100, 1'b1, 32'h33, 32'h0,  1'b1, 1'b1, 32'h108});
        vq.push_back('{1'b1, 32'h100, 1'b1, 32'h44, 32'h0,  1'b1, 1'b1, 32'h10C});
        // Hits after fill, fetch disabled, stray ack while idle
        vq.push_back('{1'b1, 32'h100, 1'b0, 32'h0,  32'h11, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 32'h104, 1'b0, 32'h0,  32'h22, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 32'h108, 1'b0, 32'h0,  32'h33, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 32'h10C, 1'b0, 32'h0,  32'h44, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b0, 32'h100, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 32'h100, 1'b1, 32'hDEAD, 32'h11, 1'b0, 1'b0, 32'h0});
        // Conflict eviction: 0x200 shares index 0; rom_addr moves mid-refill
        vq.push_back('{1'b1, 32'h200, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h0});
        vq.push_back('{1'b1, 32'h200, 1'b1, 32'h55, 32'h0,  1'b1, 1'b1, 32'h200});
        vq.push_back('{1'b1, 32'h300, 1'b1, 32'h66, 32'h0,  1'b1, 1'b1, 32'h204});
        vq.push_back('{1'b1, 32'h200, 1'b1, 32'h77, 32'h0,  1'b1, 1'b1, 32'h208});
        vq.push_back('{1'b1, 32'h200, 1'b1, 32'h88, 32'h0,  1'b1, 1'b1, 32'h20C});
        vq.push_back('{1'b1, 32'h200, 1'b0, 32'h0,  32'h55, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 32'h20C, 1'b0, 32'h0,  32'h88, 1'b0, 1'b0, 32'h0});
        vq.push_back('{1'b1, 32'h100, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 32'h0});
        vq.push_back('{1'b1, 32'h100, 1'b1, 32'h11, 32'h0,  1'b1, 1'b1, 32'h100});
        vq.push_back('{1'b1, 32'h100, 1'b1, 32'h22, 32'h0,  1'b1, 1'b1, 32'h104});
        vq.push_back('{1'b1, 32'h100, 1'b1, 32'h33, 32'h0,  1'b1, 1'b1, 32'h108});
        vq.push_back('{1'b1, 32'h100, 1'b1, 32'h44, 32'h0,  1'b1, 1'b1, 32'h10C});
        vq.push_back('{1'b1, 32'h104, 1'b0, 32'h0,  32'h22, 1'b0, 1'b0, 32'h0});

        // Reset: hold two edges; check reset state during the second cycle
        rst = 1'b1;
        rom_ce = 1'b0; rom_addr = 32'h0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        adv();
        set_in(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        expect_out("reset ce1", 32'h0, 1'b1, 1'b0, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        rom_ce = 1'b0;
        #1;
        check("reset ce0 stall", 32'(stallreq_if), 32'h0);
        check("reset ce0 inst", rom_inst, 32'h0);
        adv();
        rst = 1'b0;

        foreach (vq[i]) begin
            set_in(vq[i].ce, vq[i].addr, 1'b0, vq[i].ack, vq[i].rdata);
            expect_out($sformatf("v%0d", i), vq[i].e_inst, vq[i].e_stall, vq[i].e_req, vq[i].e_addr);
            adv();
        end

        // Wait states: ack every third cycle, address must hold between acks
        set_in(1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
        expect_out("ws miss", 32'h0, 1'b1, 1'b0, 32'h0);
        adv();
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 2; w++) begin
                set_in(1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
                expect_out($sformatf("ws wait%0d.%0d", k, w), 32'h0, 1'b1, 1'b1, 32'h400 + 32'(4 * k));
                adv();
            end
            set_in(1'b1, 32'h400, 1'b0, 1'b1, 32'hB0 + 32'(k));
            expect_out($sformatf("ws ack%0d", k), 32'h0, 1'b1, 1'b1, 32'h400 + 32'(4 * k));
            adv();
        end
        set_in(1'b1, 32'h408, 1'b0, 1'b0, 32'h0);
        expect_out("ws hit", 32'hB2, 1'b0, 1'b0, 32'h0);
        adv();

        // Flush at the second ack: refill completes but the line stays invalid
        set_in(1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
        expect_out("fr miss", 32'h0, 1'b1, 1'b0, 32'h0);
        adv();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 32'h500, (k == 1), 1'b1, 32'hC0 + 32'(k));
            expect_out($sformatf("fr ack%0d", k), 32'h0, 1'b1, 1'b1, 32'h500 + 32'(4 * k));
            adv();
        end
        set_in(1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
        expect_out("fr still miss", 32'h0, 1'b1, 1'b0, 32'h0);
        adv();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 32'h500, 1'b0, 1'b1, 32'hD0 + 32'(k));
            expect_out($sformatf("fr re%0d", k), 32'h0, 1'b1, 1'b1, 32'h500 + 32'(4 * k));
            adv();
        end
        set_in(1'b1, 32'h50C, 1'b0, 1'b0, 32'h0);
        expect_out("fr hit", 32'hD3, 1'b0, 1'b0, 32'h0);
        adv();

        // Flush in IDLE: hit still served this cycle, then a flushed miss starts nothing
        set_in(1'b1, 32'h500, 1'b1, 1'b0, 32'h0);
        expect_out("fi hit", 32'hD0, 1'b0, 1'b0, 32'h0);
        adv();
        set_in(1'b1, 32'h500, 1'b1, 1'b0, 32'h0);
        expect_out("fi cleared", 32'h0, 1'b1, 1'b0, 32'h0);
        adv();
        set_in(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        expect_out("fi no refill", 32'h0, 1'b1, 1'b0, 32'h0);
        adv();

        // Reset after the second ack aborts the refill
        set_in(1'b1, 32'h100, 1'b0, 1'b1, 32'hE0);
        expect_out("rm ack0", 32'h0, 1'b1, 1'b1, 32'h100);
        adv();
        set_in(1'b1, 32'h100, 1'b0, 1'b1, 32'hE1);
        expect_out("rm ack1", 32'h0, 1'b1, 1'b1, 32'h104);
        adv();
        rst = 1'b1;
        set_in(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        adv();
        rst = 1'b0;
        set_in(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        expect_out("rm after rst", 32'h0, 1'b1, 1'b0, 32'h0);
        check("rm mem_addr", mem_addr, 32'h0);
        adv();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 32'h100, 1'b0, 1'b1, 32'hA0 + 32'(k));
            expect_out($sformatf("rm re%0d", k), 32'h0, 1'b1, 1'b1, 32'h100 + 32'(4 * k));
            adv();
        end
        set_in(1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
        expect_out("rm hit", 32'hA1, 1'b0, 1'b0, 32'h0);
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped instruction cache between the CPU fetch port (`rom_ce`/`rom_addr`/`rom_inst`) and a multi-cycle word-wide memory bus. Returns the instruction in the same cycle on a hit. On a miss it raises a fetch-stall request and refills the whole line from memory with a req/ack handshake. The stall request feeds `ctrl` alongside `stallreq_id`/`stallreq_ex`, so `reg_pc` and `reg_if_id` hold while the refill runs.

## Interface
- `INDEX_BITS`, default 4: line index width, giving 2^INDEX_BITS lines (16).
- `OFFSET_BITS`, default 2: word-offset width, giving 2^OFFSET_BITS words per line (4).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rom_ce` in 1: fetch enable from `reg_pc`.
- `rom_addr` in 32: fetch byte address; bits [1:0] are ignored.
- `rom_inst` out 32: instruction word; combinational.
- `stallreq_if` out 1: fetch stall request to `ctrl`; combinational.
- `flush` in 1: one-cycle pulse (fence.i) that invalidates all lines.
- `mem_req` out 1: memory read request; registered.
- `mem_addr` out 32: word-aligned read address; registered.
- `mem_ack` in 1: memory data valid for the current request.
- `mem_rdata` in 32: read data; sampled when `mem_ack`=1.

## Operation
- **Address split** (defaults): word offset = `rom_addr[3:2]`, index = `rom_addr[7:4]`, tag = `rom_addr[31:8]`. In general the tag is 32-2-OFFSET_BITS-INDEX_BITS bits wide.
- **Storage:** a valid bit and a tag per line; a data array of 2^(INDEX_BITS+OFFSET_BITS) 32-bit words. The read path is asynchronous.
- **Hit:** `hit` = `rom_ce` & `valid[index]` & (`tag[index]` == tag).
  - `rom_inst` = data[index][offset] when `hit`, otherwise 32'h0.
  - `stallreq_if` = `rom_ce` & !`hit`.
- **States:** IDLE, REFILL.
- **IDLE:**
  - On `rom_ce` & !`hit` & !`flush`: latch the line base ({tag,index,OFFSET_BITS'b0,2'b0}) and the index.
  - Set `cnt`=0, `mem_req`=1, `mem_addr`=line base, and go to REFILL.
- **REFILL:**
  - `mem_req` stays 1 until the last word is acknowledged.
  - On each `mem_ack`: write `mem_rdata` to data[latched index][`cnt`], then increment `cnt`. `mem_addr` advances by 4 on the next edge.
  - On `mem_ack` with `cnt` = 2^OFFSET_BITS-1:
    - Write the latched tag.
    - Set `valid[index]`=1, unless a flush was seen during this refill.
    - Drop `mem_req` to 0 and return to IDLE.
  - `rom_addr` changes during REFILL are ignored. The refill always completes for the latched line, and the lookup is re-evaluated in IDLE.
- **Flush:**
  - In IDLE: clear all valid bits on the next edge. A miss in the same cycle does not start a refill; the refill starts in the following cycle.
  - In REFILL: clear all valid bits and set `flush_pend`. The refill continues, but the line is not marked valid. `flush_pend` clears on return to IDLE.
- **Line replacement:** a refilled line overwrites the line at its index (no other replacement policy).
- **Lookup during REFILL:** a lookup hitting a different line returns data normally. The CPU is stalled anyway, so this has no architectural effect.

## Timing
- **Reset values:** state=IDLE, all valid=0, `mem_req`=0, `mem_addr`=0, `cnt`=0, `flush_pend`=0.
  - `rom_inst`=0 and `stallreq_if`=`rom_ce` (every lookup misses).
  - Reset mid-refill aborts the refill: no line becomes valid, and `mem_req` is 0 the cycle after reset.
- **Hit latency:** 0 cycles; instruction available in the same cycle as `rom_addr`.
- **Miss latency:**
  - Cycle 0: miss detected, `stallreq_if`=1.
  - Cycle 1: `mem_req`=1.
  - After 4 acks: the line is valid on the edge of the last ack. The next cycle hits and `stallreq_if`=0.
  - With a zero-wait memory (ack in every cycle `mem_req`=1), the miss costs 5 stall cycles.
- **Handshake:** `mem_addr` is stable while `mem_req`=1 and no ack. Back-to-back acks are legal. An ack while `mem_req`=0 is ignored.
- `rom_ce`=0: `stallreq_if`=0 and `rom_inst`=0 in any state; an in-progress refill continues.

## Test plan
- **Cold miss:** after reset, `rom_ce`=1, `rom_addr`=0x100, memory returns 0x11,0x22,0x33,0x44 with one ack per cycle.
  - Required: `mem_addr` sequence 0x100,0x104,0x108,0x10C.
  - Required: 5 stall cycles, then `rom_inst`=0x11 with `stallreq_if`=0.
- **Hits after fill:** `rom_addr`=0x104, 0x108, 0x10C.
  - Required: 0x22, 0x33, 0x44 in consecutive cycles, with `stallreq_if`=0 and `mem_req`=0.
- **Wait states:** ack only every 3rd cycle. Required: `mem_addr` held between acks, and the line valid after the 4th ack.
- **Conflict eviction:** fill 0x100, then access 0x200 (same index, different tag), then 0x100 again. Required: each access misses and refills, and 0x100 misses again.
- **Flush during refill:** `flush` pulses at the 2nd ack. Required: the refill completes, the next cycle still misses, and a new refill starts.
- **Reset mid-refill:** assert `rst` after the 2nd ack. Required: next cycle `mem_req`=0 and state IDLE; a retry of 0x100 misses and performs a full 4-word refill.
